// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous RAM between the VGA scanout fetch and the
// CPU load/store port. VGA wins by fixed priority so scanout never misses its
// deadline. A starvation counter forces a CPU grant once a pending CPU request
// has been refused STARVE_MAX cycles in a row.
//
// Ports
//   CLOCK_50, RESET_N        clock (rising edge), asynchronous active-low reset
//   vga_req/vga_addr         VGA read request, held until vga_gnt
//   vga_gnt                  combinational accept strobe for VGA
//   vga_rvalid/vga_rdata     VGA read return (two cycles after accept)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_gnt
//   cpu_gnt                  combinational accept strobe for CPU
//   cpu_rvalid/cpu_rdata     CPU read return (reads only)
//   ram_addr/ram_we/ram_wdata registered RAM command
//   ram_rdata                RAM read data, one cycle after ram_addr
//   stat_vga_cnt             VGA grant count
//   stat_cpu_stall           CPU denied-cycle count
//
// Optional feature: define VRAM_ARB_STATS_EN to build the two 32-bit
// statistics counters; otherwise both stat ports are tied to zero.
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [31:0]       stat_vga_cnt,
    output logic [31:0]       stat_cpu_stall
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    // Read-return tag pipeline: vld = read in flight, own = 1 for CPU.
    logic              vld_p1_q, vld_p1_d, own_p1_q, own_p1_d;
    logic              vld_p2_q, vld_p2_d, own_p2_q, own_p2_d;
    logic              cpu_force;

    // Grant decision: a starved CPU pre-empts VGA for exactly one cycle.
    always_comb begin
        cpu_force = cpu_req && (starve_q == STARVE_LIM);
        vga_gnt   = vga_req && !cpu_force;
        cpu_gnt   = cpu_req && (cpu_force || !vga_req);
    end

    always_comb begin
        starve_d    = starve_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vld_p1_d    = 1'b0;
        own_p1_d    = 1'b0;
        vld_p2_d    = vld_p1_q;
        own_p2_d    = own_p1_q;

        if (!cpu_req || cpu_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end

        // Stage 0 -> 1: register the winner's command and tag reads.
        if (vga_gnt) begin
            ram_addr_d = vga_addr;
            vld_p1_d   = 1'b1;
            own_p1_d   = 1'b0;
        end else if (cpu_gnt) begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            vld_p1_d    = !cpu_we;
            own_p1_d    = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_q    <= 4'd0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vld_p1_q    <= 1'b0;
            own_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            own_p2_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vld_p1_q    <= vld_p1_d;
            own_p1_q    <= own_p1_d;
            vld_p2_q    <= vld_p2_d;
            own_p2_q    <= own_p2_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    // Stage 2: RAM data is on ram_rdata now; steer the strobe to its owner.
    assign vga_rvalid = vld_p2_q && !own_p2_q;
    assign cpu_rvalid = vld_p2_q &&  own_p2_q;
    assign vga_rdata  = ram_rdata;
    assign cpu_rdata  = ram_rdata;

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_vga_q, stat_vga_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_vga_d   = stat_vga_q + {31'd0, vga_gnt};
        stat_stall_d = stat_stall_q + {31'd0, (cpu_req && !cpu_gnt)};
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_vga_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_vga_q   <= stat_vga_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_vga_cnt   = stat_vga_q;
    assign stat_cpu_stall = stat_stall_q;
`else
    assign stat_vga_cnt   = 32'd0;
    assign stat_cpu_stall = 32'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter. The RAM model preloads word a with
// a ^ 16'h5A5A, so RAM[0x0100] = 0x5B5A, RAM[0x0200] = 0x585A,
// RAM[0x0010] = 0x5A4A.
module tb_vram_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int STARVE_MAX = 4;
`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt, vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [31:0]       stat_vga_cnt, stat_cpu_stall;

    always #5 CLOCK_50 = ~CLOCK_50;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .stat_vga_cnt(stat_vga_cnt), .stat_cpu_stall(stat_cpu_stall)
    );

    // Synchronous single-port RAM model, read-before-write.
    logic [15:0] mem [logic [15:0]];
    always @(posedge CLOCK_50) begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : (ram_addr ^ 16'h5A5A);
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t vga_q[$];
    exp_t cpu_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per rvalid strobe.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (vga_rvalid) begin
            chk("vga_rvalid_expected", 32'(vga_q.size() != 0), 32'd1);
            if (vga_q.size() != 0) begin
                e = vga_q.pop_front();
                chk("vga_rdata", 32'(vga_rdata), 32'(e.data));
                chk("vga_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (cpu_rvalid) begin
            chk("cpu_rvalid_expected", 32'(cpu_q.size() != 0), 32'd1);
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                chk("cpu_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one CPU access; returns just after the edge following the grant.
    task automatic cpu_access(input logic we, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] exp_d);
        bit got = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLOCK_50);
            if (cpu_gnt) begin
                got = 1'b1;
                if (!we) cpu_q.push_back('{exp_d, cyc + 2});
            end else begin
                @(posedge CLOCK_50); #1;
            end
        end
        chk("cpu_gnt_within_budget", 32'(got), 32'd1);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0033; cpu_wdata = 16'h1234;

        // Reset with requests active: nothing registered, gnt still combinational.
        repeat (4) begin
            @(posedge CLOCK_50); #1;
            vga_req  = 1'($urandom_range(0, 1));
            vga_addr = 16'($urandom);
            @(negedge CLOCK_50);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("rst_cpu_gnt_comb", 32'(cpu_gnt), 32'(!vga_req));
        end
        @(posedge CLOCK_50); #1;
        vga_req = 1'b0;
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        chk("post_rst_ram_we", 32'(ram_we), 32'd1);
        chk("post_rst_ram_addr", 32'(ram_addr), 32'h0033);
        chk("post_rst_ram_wdata", 32'(ram_wdata), 32'h1234);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        chk("idle_ram_we", 32'(ram_we), 32'd0);
        chk("idle_ram_addr_hold", 32'(ram_addr), 32'h0033);
        chk("idle_ram_wdata_hold", 32'(ram_wdata), 32'h1234);
        @(posedge CLOCK_50); #1;

        // CPU write then read-back of the same word.
        cpu_access(1'b1, 16'h0012, 16'hBEEF, 16'h0000);
        cpu_access(1'b0, 16'h0012, 16'h0000, 16'hBEEF);
        repeat (3) @(posedge CLOCK_50);
        #1;

        // Simultaneous requests: VGA first, CPU next cycle (interleaved reads).
        vga_req = 1'b1; vga_addr = 16'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
        @(negedge CLOCK_50);
        chk("simul_vga_gnt", 32'(vga_gnt), 32'd1);
        chk("simul_cpu_gnt", 32'(cpu_gnt), 32'd0);
        vga_q.push_back('{16'h5B5A, cyc + 2});
        @(posedge CLOCK_50); #1;
        vga_req = 1'b0;
        @(negedge CLOCK_50);
        chk("interleave_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("interleave_vga_gnt", 32'(vga_gnt), 32'd0);
        cpu_q.push_back('{16'h585A, cyc + 2});
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;

        // Starvation: VGA held, CPU write wins on its 5th request cycle.
        vga_req = 1'b1; vga_addr = 16'h0010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hCAFE;
        for (int k = 1; k <= STARVE_MAX + 1; k++) begin
            @(negedge CLOCK_50);
            chk($sformatf("starve_cpu_gnt_c%0d", k), 32'(cpu_gnt), 32'(k == STARVE_MAX + 1));
            chk($sformatf("starve_vga_gnt_c%0d", k), 32'(vga_gnt), 32'(k != STARVE_MAX + 1));
            if (k != STARVE_MAX + 1) vga_q.push_back('{16'h5A4A, cyc + 2});
            @(posedge CLOCK_50); #1;
        end
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        chk("starve_vga_retry", 32'(vga_gnt), 32'd1);
        vga_q.push_back('{16'h5A4A, cyc + 2});
        @(posedge CLOCK_50); #1;
        vga_req = 1'b0;
        cpu_access(1'b0, 16'h0020, 16'h0000, 16'hCAFE);
        repeat (3) @(posedge CLOCK_50);
        #1;

        // Reset right after a VGA accept: the read must never return.
        vga_req = 1'b1; vga_addr = 16'h0040;
        @(negedge CLOCK_50);
        chk("midrst_vga_gnt", 32'(vga_gnt), 32'd1);
        @(posedge CLOCK_50); #1;
        vga_req = 1'b0;
        RESET_N = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("midrst_no_rvalid", 32'(vga_rvalid | cpu_rvalid), 32'd0);
        end
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        chk("stat_vga_after_rst", stat_vga_cnt, 32'd0);
        chk("stat_stall_after_rst", stat_cpu_stall, 32'd0);
        @(posedge CLOCK_50); #1;

        // Statistics: 10 VGA grants, CPU denied on the last 3 of them.
        vga_req = 1'b1; vga_addr = 16'h0010;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777;
            end
            @(negedge CLOCK_50);
            chk($sformatf("stats_vga_gnt_c%0d", k), 32'(vga_gnt), 32'd1);
            vga_q.push_back('{16'h5A4A, cyc + 2});
            @(posedge CLOCK_50); #1;
        end
        vga_req = 1'b0;
        @(negedge CLOCK_50);
        chk("stats_cpu_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        chk("stat_vga_cnt", stat_vga_cnt, STATS ? 32'd10 : 32'd0);
        chk("stat_cpu_stall", stat_cpu_stall, STATS ? 32'd3 : 32'd0);

        repeat (5) @(negedge CLOCK_50);
        chk("vga_queue_drained", 32'(vga_q.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates one single-port synchronous video/data RAM between two requesters: the VGA scanout pixel fetch and the CPU load/store port. VGA has fixed priority so scanout never misses a deadline; a bounded-starvation counter guarantees the CPU forward progress. The block sits between the CPU control path, the VGA/PS2 display path, and the shared RAM macro in the top-level CPU design.

## Interface
Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, RAM data width.
- STARVE_MAX, 4, maximum consecutive cycles a pending CPU request may be denied; legal range 1–15.

Ports:
- CLOCK_50  in  1  single system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request; held until accepted.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  combinational; VGA request accepted this cycle.
- vga_rvalid  out  1  VGA read data valid.
- vga_rdata  out  DATA_W  VGA read data.
- cpu_req  in  1  CPU request; held until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid (reads only).
- cpu_rdata  out  DATA_W  CPU read data.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_addr is presented.
- stat_vga_cnt  out  32  count of VGA grants (see Configuration).
- stat_cpu_stall  out  32  count of CPU denied cycles (see Configuration).

## Operation
- A request is accepted in any cycle where req && gnt. At most one grant is issued per cycle.
- Grant rule:
  - If starve_cnt == STARVE_MAX and cpu_req, grant the CPU.
  - Otherwise, if vga_req, grant VGA.
  - Otherwise, if cpu_req, grant the CPU.
  - Otherwise, no grant.
- starve_cnt (4 bits):
  - Increments each cycle cpu_req is high and cpu_gnt is low.
  - Clears on cpu_gnt, or in any cycle cpu_req is low.
  - Saturates at STARVE_MAX.
- Accept edge: ram_addr, ram_we and ram_wdata register the granted requester's address, write enable and data. ram_we is 1 only for an accepted CPU write.
- Idle cycle (no grant): ram_we ← 0; ram_addr and ram_wdata hold their previous values.
- Read-return pipeline: 2-stage tag shift register {valid, owner}.
  - Stage 1 loads on the accept edge for reads only.
  - Stage 2 drives rvalid for the tagged owner.
  - vga_rdata and cpu_rdata both equal ram_rdata combinationally; only the rvalid strobes differ.
- Writes produce no rvalid. A read following a write to the same address returns the new data, because the RAM commits in order.
- Requesters must hold req, addr, we and wdata stable until they see gnt high.

## Timing
- Reset (RESET_N low, asynchronous): vga_gnt and cpu_gnt follow their inputs combinationally, but no acceptance is registered while reset is asserted. All registered state resets as follows:
  - ram_addr = 0, ram_we = 0, ram_wdata = 0.
  - vga_rvalid = 0, cpu_rvalid = 0.
  - starve_cnt = 0, pipeline tags = 0, stat counters = 0.
- Read latency: accept in cycle N → rvalid high and data valid in cycle N+2, for exactly one cycle.
- Write: accepted in cycle N; RAM written at the end of cycle N+1.
- Throughput: one access per cycle, with back-to-back grants allowed.
- Worst case under continuous vga_req: the CPU is granted on the (STARVE_MAX+1)th cycle of its request. In that cycle VGA is denied and retries the next cycle.
- Reset asserted mid-transaction: in-flight reads are dropped and no rvalid is issued. Requesters reissue after reset.

## Configuration
- VRAM_ARB_STATS_EN:
  - Defined: stat_vga_cnt increments on every vga_gnt, and stat_cpu_stall increments on every cycle with cpu_req && !cpu_gnt. Both are 32-bit counters that wrap modulo 2^32 and reset to 0.
  - Undefined: no counter logic is built, and both ports are tied to 0.

## Test plan
- Reset: hold RESET_N low with random requests → ram_we = 0, both rvalid = 0, ram_addr = 0. Release → first request is accepted in the following cycle.
- Single CPU write, then read: write addr 0x0012 / data 0xBEEF, then read 0x0012 → cpu_rvalid pulses 2 cycles after the read accept with cpu_rdata = 0xBEEF, and vga_rvalid stays 0.
- Simultaneous requests, starve_cnt = 0: vga_req and cpu_req both high → vga_gnt = 1 and cpu_gnt = 0 that cycle.
- Starvation: vga_req held high continuously, cpu_req high with STARVE_MAX = 4 → cpu_gnt first high on the 5th request cycle with vga_gnt low in that cycle; VGA is granted again the next cycle.
- Interleaved reads: VGA read 0x0100 at N, CPU read 0x0200 at N+1 → vga_rvalid at N+2 with RAM[0x0100], cpu_rvalid at N+3 with RAM[0x0200].
- Stats (VRAM_ARB_STATS_EN defined): 10 VGA grants and 3 CPU stall cycles → stat_vga_cnt = 10, stat_cpu_stall = 3. Macro undefined → both read 0.
